pc_fetch_unit: RTL

Instruction-fetch front end of the RISC_V core. It holds the program counter that drives the combinational instruction memory, samples the returned instruction word, and registers it into the IF/ID pipeline register for decode. It handles stall, branch/jump redirect with flush, and an EBREAK-triggered halt/resume state machine.

---
 rtl/pc_fetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: program counter, IF/ID register, stall/redirect handling and EBREAK halt.
// Optional build macro FETCH_MISALIGN_CHK_EN rejects misaligned redirects and raises a sticky misalign_o.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        resume_i,
  input  logic [31:0] instruction_i,
  output logic [31:0] pc_o,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_plus4_o,
  output logic        halted_o,
  output logic        misalign_o
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc_p0;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        redirect_ok;
  logic        redirect_bad;

  assign pc_plus4 = pc_p0 + 32'd4;
  assign pc_o     = pc_p0;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redirect_ok     = redirect_valid_i && (redirect_pc_i[1:0] == 2'b00);
  assign redirect_bad    = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign redirect_target = redirect_pc_i;

  logic misalign_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign_q <= 1'b0;
    else if (state != BOOT && redirect_bad)
      misalign_q <= 1'b1;
  end
  assign misalign_o = misalign_q;
`else
  // Low address bits are simply dropped, so a misaligned target lands on its word.
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc_i[1:0];
  assign redirect_ok     = redirect_valid_i;
  assign redirect_bad    = 1'b0;
  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
  assign misalign_o      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      pc_p0         <= RESET_PC;
      id_valid_o    <= 1'b0;
      id_pc_o       <= 32'd0;
      id_instr_o    <= NOP_INSTR;
      id_pc_plus4_o <= 32'd4;
      halted_o      <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          id_valid_o <= 1'b0;
          id_instr_o <= NOP_INSTR;
          state      <= RUN;
        end
        RUN: begin
          if (redirect_valid_i) begin
            // Flush wins over stall; a rejected target falls back to sequential flow.
            id_valid_o <= 1'b0;
            id_instr_o <= NOP_INSTR;
            if (redirect_ok)
              pc_p0 <= redirect_target;
            else if (!stall_i)
              pc_p0 <= pc_plus4;
          end else if (!stall_i) begin
            pc_p0         <= pc_plus4;
            id_valid_o    <= 1'b1;
            id_pc_o       <= pc_p0;
            id_instr_o    <= instruction_i;
            id_pc_plus4_o <= pc_plus4;
            if (instruction_i == EBREAK) begin
              state    <= HALT;
              halted_o <= 1'b1;
            end
          end
        end
        HALT: begin
          if (redirect_ok)
            pc_p0 <= redirect_target;
          if (redirect_valid_i || !stall_i) begin
            id_valid_o <= 1'b0;
            id_instr_o <= NOP_INSTR;
          end
          if (resume_i) begin
            state    <= RUN;
            halted_o <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
